rr_stream_mux: RTL and testbench
================================

Name: rr_stream_mux

Overview:
- Parametrised N:1 registered stream multiplexer; next generation of the 2:1 combinational mux.
- Selects among CHANNELS valid/ready input streams by round-robin arbitration or by a fixed select, and presents the winner on one registered output stream.
- Sits between parallel cipher/datapath lanes and a single shared consumer, e.g. the output serialiser.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (≥2).
- SEL_W, $clog2(CHANNELS), width of channel index fields.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- mode  input  1  0 = round-robin, 1 = fixed select.
- fixed_sel  input  SEL_W  channel index used when mode=1.
- in_data  input  CHANNELS*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready, one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n=0, takes effect immediately): out_valid=0, out_data=0, out_chan=0, last_grant=CHANNELS-1. Channel 0 therefore has first priority after reset. in_ready=0 while rst_n=0.
- Output stage: one-entry register.
  - load_en = !out_valid || out_ready.
  - A word in the register is drained on any cycle with out_valid && out_ready.
  - Sustains 1 word/cycle when out_ready is held high.
- Eligibility is combinational in the current cycle:
  - mode=0: every channel with in_valid=1 is eligible.
  - mode=1: only channel fixed_sel is eligible, and only if in_valid[fixed_sel]=1.
  - fixed_sel ≥ CHANNELS: no channel is eligible.
- Round-robin grant: the first eligible channel searching upward from (last_grant+1) mod CHANNELS, wrapping past CHANNELS-1 to 0.
- Fixed grant: fixed_sel when it is eligible.
- in_ready[g] = load_en && a grant exists; every other bit of in_ready is 0. in_ready never depends on out_valid alone.
- Transfer on channel g when in_valid[g] && in_ready[g]. At the next edge:
  - out_data <= in_data[g]
  - out_chan <= g
  - out_valid <= 1
  - last_grant <= g (updated in both modes)
- Latency: 1 cycle from input transfer to out_valid.
- Drain with no new transfer: out_valid <= 0. out_data and out_chan hold their last values.
- Simultaneous drain and load: the register is replaced in the same edge and out_valid stays 1 (no bubble).
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid stay stable; in_ready=0.
- A change to mode or fixed_sel during a stall does not alter the held word. The new mode applies to the next grant.
- Unselected channels keep their data pending; nothing is dropped or duplicated.
- Reset asserted mid-stream discards the held word; no partial state survives.
- No combinational path from out_ready to out_data.

Test Plan:
- Reset then single channel: rst_n low 3 cycles, release; in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=A5, out_chan=2.
- Round-robin fairness: all 4 channels valid continuously with data 8'h10/11/12/13, out_ready=1 -> out_chan sequence 0,1,2,3,0,1…, one word per cycle, no bubbles.
- Skip and wrap: last_grant=2, in_valid=4'b0011 -> grant ch0; then with only ch1 valid -> grant ch1 (the wrap from index 3 to 0 is exercised).
- Backpressure: out_ready=0 for 5 cycles with all channels valid -> out_data/out_chan frozen and in_ready=0; out_ready=1 -> the next grant follows last_grant and no word is lost.
- Fixed mode: mode=1, fixed_sel=3, all valid -> only ch3 ever granted (out_chan=3 repeatedly). Set fixed_sel=5 with CHANNELS=8 and in_valid[5]=0 -> no transfer, out_valid drops after the drain.
- Async reset mid-stream: assert rst_n between clock edges while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge; after release the first grant goes to ch0 when all channels are valid.

Source files
------------

// File: rtl/rr_stream_mux.sv
// N:1 registered stream multiplexer: round-robin or fixed-select arbitration
// feeding a one-entry output register with full-throughput valid/ready handshake.
module rr_stream_mux #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          fixed_sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [SEL_W-1:0]    last_grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    cand;
    logic [CHANNELS-1:0] fixed_hit;
    logic [CHANNELS-1:0] elig;
    logic                grant_found;
    logic                load_en;
    logic                take;

    // Decode fixed_sel; an index past the last channel matches nothing.
    always_comb begin
        fixed_hit = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            fixed_hit[i] = (fixed_sel == SEL_W'(i));
        end
    end

    assign elig = mode ? (in_valid & fixed_hit) : in_valid;

    // Upward search starting just after the last winner, wrapping to channel 0.
    // In fixed mode at most one bit of elig is set, so the same search yields fixed_sel.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            cand = SEL_W'((32'(last_grant) + k) % CHANNELS);
            if (!grant_found && elig[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign load_en = !out_valid || out_ready;
    assign take    = load_en && grant_found;

    // Held low during reset even though load_en is high with the register empty.
    assign in_ready = (rst_n && take) ? (CHANNELS'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= SEL_W'(CHANNELS - 1);
        end else if (load_en) begin
            if (take) begin
                out_data   <= WIDTH'(in_data >> (32'(grant_idx) * WIDTH));
                out_chan   <= grant_idx;
                out_valid  <= 1'b1;
                last_grant <= grant_idx;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: behavioural arbiter model feeds a scoreboard
// queue that is checked as the output register drains.
module tb_rr_stream_mux;

    localparam int unsigned W  = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned SW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic            mode;
    logic [SW-1:0]   fixed_sel;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_chan;
    logic            out_valid;
    logic            out_ready;

    logic        mode8;
    logic [2:0]  fixed_sel8;
    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  in_ready8;
    logic [7:0]  out_data8;
    logic [2:0]  out_chan8;
    logic        out_valid8;
    logic        out_ready8;

    rr_stream_mux #(.WIDTH(W), .CHANNELS(CH)) u_dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .fixed_sel(fixed_sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    rr_stream_mux #(.WIDTH(8), .CHANNELS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .fixed_sel(fixed_sel8),
        .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
        .out_data(out_data8), .out_chan(out_chan8), .out_valid(out_valid8),
        .out_ready(out_ready8)
    );

    typedef struct packed {
        logic [SW-1:0] chan;
        logic [W-1:0]  data;
    } word_t;

    word_t       sb[$];
    logic        m_valid;
    logic [SW-1:0] m_last;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the arbiter at the negedge, check, then advance model state.
    task automatic cycle();
        logic [CH-1:0] elig;
        logic [CH-1:0] exp_ready;
        logic [SW-1:0] idx;
        logic [SW-1:0] g;
        logic          load;
        logic          found;
        word_t         w;
        @(negedge clk);
        elig = '0;
        if (rst_n) begin
            if (!mode) elig = in_valid;
            else elig[fixed_sel] = in_valid[fixed_sel];
        end
        load  = !m_valid || out_ready;
        found = 1'b0;
        g     = '0;
        for (int k = 1; k <= int'(CH); k++) begin
            idx = SW'((int'(m_last) + k) % int'(CH));
            if (!found && elig[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
        exp_ready = (load && found) ? (CH'(1) << g) : '0;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        if (m_valid && !out_ready && sb.size() > 0) begin
            chk("stall_data", 64'(out_data), 64'(sb[0].data));
            chk("stall_chan", 64'(out_chan), 64'(sb[0].chan));
        end
        if (m_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_underflow observed=drain expected=empty");
            end else begin
                w = sb.pop_front();
                chk("out_data", 64'(out_data), 64'(w.data));
                chk("out_chan", 64'(out_chan), 64'(w.chan));
            end
        end
        if (load && found) begin
            w.chan = g;
            w.data = W'(in_data >> (int'(g) * int'(W)));
            sb.push_back(w);
        end
        @(posedge clk);
        if (rst_n) begin
            if (load) m_valid = found;
            if (load && found) m_last = g;
        end
        #1;
    endtask

    initial begin
        mode = 1'b0; fixed_sel = '0; in_data = '0; in_valid = 4'hF; out_ready = 1'b1;
        mode8 = 1'b1; fixed_sel8 = '0; in_data8 = '0; in_valid8 = '0; out_ready8 = 1'b1;
        m_valid = 1'b0; m_last = SW'(CH - 1);

        // Reset: asserted between edges, outputs clear at once
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_chan", 64'(out_chan), 64'(0));
        chk("rst_ready", 64'(in_ready), 64'(0));
        repeat (3) cycle();
        rst_n = 1'b1;

        // Single channel 2
        in_valid = 4'b0100;
        in_data  = 32'h00A5_0000;
        #1 chk("single_ready", 64'(in_ready), 64'(4'b0100));
        cycle();
        in_valid = '0;
        chk("single_data", 64'(out_data), 64'(8'hA5));
        chk("single_chan", 64'(out_chan), 64'(2));
        cycle();

        // Round-robin fairness, all valid
        in_data  = 32'h1312_1110;
        in_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) chk("rr_seq", 64'(out_chan), 64'((2 + i) % 4));
            cycle();
        end

        // Skip and wrap from last_grant=2
        in_valid = 4'b0011;
        #1 chk("wrap_ch0", 64'(in_ready), 64'(4'b0001));
        cycle();
        in_valid = 4'b0010;
        #1 chk("then_ch1", 64'(in_ready), 64'(4'b0010));
        cycle();

        // Backpressure
        in_valid = 4'hF;
        cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        #1 chk("bp_resume", 64'(in_ready), 64'(4'b1000));
        repeat (3) cycle();

        // Fixed mode on channel 3, then switch back during a stall
        mode = 1'b1;
        fixed_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) chk("fixed_chan", 64'(out_chan), 64'(3));
            cycle();
        end
        out_ready = 1'b0;
        mode = 1'b0;
        repeat (2) cycle();
        out_ready = 1'b1;
        #1 chk("mode_switch", 64'(in_ready), 64'(4'b0001));
        repeat (2) cycle();

        // 8-channel instance: fixed_sel=5, then channel 5 goes idle
        in_valid   = '0;
        fixed_sel8 = 3'd5;
        in_valid8  = 8'hFF;
        in_data8   = 64'h8786_8584_8382_8180;
        #1 chk("f8_ready", 64'(in_ready8), 64'(8'h20));
        cycle();
        in_valid8 = 8'hDF;
        #1;
        chk("f8_valid", 64'(out_valid8), 64'(1));
        chk("f8_chan", 64'(out_chan8), 64'(5));
        chk("f8_data", 64'(out_data8), 64'(8'h85));
        chk("f8_noready", 64'(in_ready8), 64'(0));
        cycle();
        #1;
        chk("f8_drained", 64'(out_valid8), 64'(0));
        chk("f8_hold", 64'(out_data8), 64'(8'h85));

        // Async reset mid-stream while a word is held
        in_valid = 4'hF;
        cycle();
        out_ready = 1'b0;
        cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_data", 64'(out_data), 64'(0));
        chk("ar_ready", 64'(in_ready), 64'(0));
        sb.delete();
        m_valid = 1'b0;
        m_last  = SW'(CH - 1);
        repeat (2) cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("ar_first", 64'(in_ready), 64'(4'b0001));
        repeat (3) cycle();

        in_valid = '0;
        repeat (2) cycle();
        chk("sb_left", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
